vita_tx_err_reporter: RTL and testbench

- Downstream of the TX VITA control stage: consumes its one-cycle error/ack pulses plus the 32-bit error code and emits one 5-word VITA extension-context packet per event.
- Output is a 36-bit fifo36-style stream on the TX control/async-message path back to the host.
- Each event is timestamped with the VITA time sampled in the cycle it occurs.
- A one-deep pending slot absorbs events that arrive while a packet is being sent; further events are dropped and counted.

---
 rtl/vita_tx_err_reporter_pkg.sv | 55 +++++
 rtl/vita_tx_err_reporter_slot.sv | 34 +++
 rtl/vita_tx_err_reporter.sv | 146 ++++++++++++++
 tb/tb_vita_tx_err_reporter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/vita_tx_err_reporter_pkg.sv
// Shared types and constants for the TX VITA error/ack reporter: FSM encoding,
// packet word layout and the fifo36 framing bit positions.
package vita_tx_err_reporter_pkg;

   localparam int unsigned W_HDR    = 0;
   localparam int unsigned W_SID    = 1;
   localparam int unsigned W_TSI_HI = 2;
   localparam int unsigned W_TSF_LO = 3;
   localparam int unsigned W_CODE   = 4;

   localparam int unsigned SOF_BIT = 32;
   localparam int unsigned EOF_BIT = 33;

   localparam logic [1:0]  TSI_NONE    = 2'b00;
   localparam logic [1:0]  TSF_SAMPLES = 2'b01;
   localparam logic [15:0] PKT_LEN     = 16'd5;

   // Non-idle states share their encoding with the word index they emit.
   typedef enum logic [2:0] {
      ST_HDR    = 3'(W_HDR),
      ST_SID    = 3'(W_SID),
      ST_TSI_HI = 3'(W_TSI_HI),
      ST_TSF_LO = 3'(W_TSF_LO),
      ST_CODE   = 3'(W_CODE),
      ST_IDLE   = 3'd7
   } state_e;

   typedef struct packed {
      logic [31:0] code;
      logic [63:0] vtime;
      logic [31:0] sid;
   } err_evt_t;

   function automatic logic [35:0] fmt_word(input state_e st, input err_evt_t ev,
                                            input logic [3:0] ptype, input logic [3:0] cnt);
      logic [35:0] w;
      w = '0;
      case (st)
         ST_HDR: begin
            w[31:0]     = {ptype, 4'h0, TSI_NONE, TSF_SAMPLES, cnt, PKT_LEN};
            w[SOF_BIT]  = 1'b1;
         end
         ST_SID:    w[31:0] = ev.sid;
         ST_TSI_HI: w[31:0] = ev.vtime[63:32];
         ST_TSF_LO: w[31:0] = ev.vtime[31:0];
         ST_CODE: begin
            w[31:0]     = ev.code;
            w[EOF_BIT]  = 1'b1;
         end
         default:   w = '0;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/vita_tx_err_reporter_slot.sv
// One event holding register with a valid bit; a load in the same cycle as a
// take (or clear) wins, so the slot can be refilled while it is being emptied.
module vita_err_event_slot
   import vita_tx_err_reporter_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     clear_i,
   input  logic     load_i,
   input  logic     take_i,
   input  err_evt_t evt_i,
   output err_evt_t evt_o,
   output logic     valid_o
);

   err_evt_t evt_q;
   logic     valid_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         evt_q   <= '0;
         valid_q <= 1'b0;
      end else if (load_i) begin
         evt_q   <= evt_i;
         valid_q <= 1'b1;
      end else if (take_i || clear_i) begin
         valid_q <= 1'b0;
      end
   end

   assign evt_o   = evt_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/vita_tx_err_reporter.sv
// Turns TX VITA error/ack pulses into 5-word extension-context packets on a
// fifo36 stream, with a one-deep pending slot and a saturating drop counter.
module vita_tx_err_reporter
   import vita_tx_err_reporter_pkg::*;
#(
   parameter logic [31:0] SID_DEFAULT = 32'h0,
   parameter logic [3:0]  PKT_TYPE    = 4'h5
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        error,
   input  logic        ack,
   input  logic [31:0] error_code,
   input  logic [63:0] vita_time,
   input  logic [31:0] sid,
   input  logic        sid_valid,
   output logic [35:0] o_data,
   output logic        o_src_rdy,
   input  logic        o_dst_rdy,
   output logic [15:0] dropped,
   output logic        busy
);

   state_e      state_q, state_d;
   logic [3:0]  pkt_cnt_q, pkt_cnt_d;
   logic [15:0] dropped_q, dropped_d;
   logic [35:0] o_data_q, o_data_d;

   err_evt_t evt_rec, act_q, pend_q, act_load_data, act_next;
   logic     act_valid, pend_valid;
   logic     act_load, act_take, pend_load, pend_take;
   logic     evt, accept, last_accept, pend_live, drop_evt;

   vita_err_event_slot u_active (
      .clk     (clk),
      .reset   (reset),
      .clear_i (1'b0),
      .load_i  (act_load),
      .take_i  (act_take),
      .evt_i   (act_load_data),
      .evt_o   (act_q),
      .valid_o (act_valid)
   );

   vita_err_event_slot u_pending (
      .clk     (clk),
      .reset   (reset),
      .clear_i (clear),
      .load_i  (pend_load),
      .take_i  (pend_take),
      .evt_i   (evt_rec),
      .evt_o   (pend_q),
      .valid_o (pend_valid)
   );

   always_comb begin
      evt           = (error | ack) & ~clear;
      evt_rec.code  = error_code;
      evt_rec.vtime = vita_time;
      evt_rec.sid   = sid_valid ? sid : SID_DEFAULT;
      pend_live     = pend_valid & ~clear;
      accept        = (state_q != ST_IDLE) & o_dst_rdy;
      last_accept   = (state_q == ST_CODE) & o_dst_rdy;

      state_d       = state_q;
      act_load      = 1'b0;
      act_take      = 1'b0;
      act_load_data = evt_rec;
      pend_load     = 1'b0;
      pend_take     = 1'b0;
      drop_evt      = 1'b0;

      if (state_q == ST_IDLE) begin
         // A held pending event goes first; a same-cycle new event refills pending.
         if (pend_live) begin
            act_load      = 1'b1;
            act_load_data = pend_q;
            pend_take     = 1'b1;
            pend_load     = evt;
            state_d       = ST_HDR;
         end else if (evt) begin
            act_load = 1'b1;
            state_d  = ST_HDR;
         end
      end else begin
         if (evt) begin
            if (pend_live) drop_evt  = 1'b1;
            else           pend_load = 1'b1;
         end
         if (accept) begin
            case (state_q)
               ST_HDR:    state_d = ST_SID;
               ST_SID:    state_d = ST_TSI_HI;
               ST_TSI_HI: state_d = ST_TSF_LO;
               ST_TSF_LO: state_d = ST_CODE;
               default:   state_d = state_q;
            endcase
         end
         if (last_accept) begin
            if (pend_live) begin
               act_load      = 1'b1;
               act_load_data = pend_q;
               pend_take     = 1'b1;
               state_d       = ST_HDR;
            end else begin
               act_take = 1'b1;
               state_d  = ST_IDLE;
            end
         end
      end

      pkt_cnt_d = pkt_cnt_q;
      if (clear)            pkt_cnt_d = '0;
      else if (last_accept) pkt_cnt_d = pkt_cnt_q + 4'd1;

      dropped_d = dropped_q;
      if (clear)                            dropped_d = '0;
      else if (drop_evt && dropped_q != '1) dropped_d = dropped_q + 16'd1;

      // Output word is registered from the next state so it stays frozen until accepted.
      act_next = act_load ? act_load_data : act_q;
      if (state_q != ST_IDLE && !o_dst_rdy) o_data_d = o_data_q;
      else                                  o_data_d = fmt_word(state_d, act_next, PKT_TYPE, pkt_cnt_d);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         pkt_cnt_q <= '0;
         dropped_q <= '0;
         o_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         pkt_cnt_q <= pkt_cnt_d;
         dropped_q <= dropped_d;
         o_data_q  <= o_data_d;
      end
   end

   assign o_data    = o_data_q;
   assign o_src_rdy = (state_q != ST_IDLE);
   assign dropped   = dropped_q;
   assign busy      = act_valid | pend_valid;

endmodule

// File: tb/tb_vita_tx_err_reporter.sv
// Randomized scoreboard bench for vita_tx_err_reporter against a packet-level model.
module tb_vita_tx_err_reporter;

   localparam logic [31:0] SID_DEF = 32'h5A5A_0001;

   typedef struct {
      logic [31:0] code;
      logic [63:0] t;
      logic [31:0] sid;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1, clear = 1'b0, error = 1'b0, ack = 1'b0;
   logic [31:0] error_code = '0, sid = '0;
   logic [63:0] vita_time = '0;
   logic        sid_valid = 1'b0, o_dst_rdy = 1'b0;
   logic [35:0] o_data;
   logic        o_src_rdy, busy;
   logic [15:0] dropped;

   always #5 clk = ~clk;

   vita_tx_err_reporter #(.SID_DEFAULT(SID_DEF), .PKT_TYPE(4'h5)) dut (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .error      (error),
      .ack        (ack),
      .error_code (error_code),
      .vita_time  (vita_time),
      .sid        (sid),
      .sid_valid  (sid_valid),
      .o_data     (o_data),
      .o_src_rdy  (o_src_rdy),
      .o_dst_rdy  (o_dst_rdy),
      .dropped    (dropped),
      .busy       (busy)
   );

   int unsigned vectors = 0, miscompares = 0;

   // Model: words left in the packet being sent, one optional held event, counters.
   logic [35:0] expq[$];
   int  rem = 0, cnt = 0, drop = 0;
   bit  pend = 1'b0, just_reset = 1'b0;
   ev_t pev;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void start_pkt(input ev_t e);
      logic [31:0] hdr;
      hdr = 32'h5010_0005 | (32'(cnt) << 16);
      expq.push_back(36'h1_0000_0000 | {4'h0, hdr});
      expq.push_back({4'h0, e.sid});
      expq.push_back({4'h0, e.t[63:32]});
      expq.push_back({4'h0, e.t[31:0]});
      expq.push_back(36'h2_0000_0000 | {4'h0, e.code});
      rem = 5;
   endfunction

   always @(posedge clk) begin
      ev_t nev;
      bit  evt, pl;
      if (reset) begin
         rem = 0; pend = 1'b0; cnt = 0; drop = 0;
         expq.delete();
         just_reset = 1'b1;
      end else begin
         just_reset = 1'b0;
         evt      = (error || ack) && !clear;
         nev.code = error_code;
         nev.t    = vita_time;
         nev.sid  = sid_valid ? sid : SID_DEF;
         pl       = pend && !clear;
         if (rem == 0) begin
            if (pl) begin
               start_pkt(pev);
               pend = evt;
               pev  = nev;
            end else if (evt) begin
               start_pkt(nev);
            end
         end else begin
            if (evt) begin
               if (pl) begin
                  if (drop < 65535) drop++;
               end else begin
                  pend = 1'b1;
                  pev  = nev;
               end
            end
            if (o_dst_rdy) begin
               rem--;
               if (rem == 0) begin
                  cnt = (cnt + 1) % 16;
                  if (pl) begin
                     pend = 1'b0;
                     start_pkt(pev);
                  end
               end
            end
         end
         if (clear) begin
            pend = 1'b0; cnt = 0; drop = 0;
         end
      end
   end

   always @(negedge clk) begin
      chk("o_src_rdy", 64'(o_src_rdy), 64'(rem > 0));
      chk("busy", 64'(busy), 64'(rem > 0 || pend));
      chk("dropped", 64'(dropped), 64'(drop));
      if (just_reset) chk("reset_o_data", 64'(o_data), 64'd0);
      if (o_src_rdy === 1'b1) begin
         if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL word: got %h expected no word at %0t", o_data, $time);
         end else begin
            chk("word", 64'(o_data), 64'(expq[0]));
            if (o_dst_rdy) void'(expq.pop_front());
         end
      end
   end

   task automatic step(input bit e, input bit a, input bit c, input bit d, input bit r = 1'b0);
      @(posedge clk);
      #1;
      reset      = r;
      error      = e;
      ack        = a;
      clear      = c;
      o_dst_rdy  = d;
      error_code = $urandom;
      vita_time  = {$urandom, $urandom};
      sid        = $urandom;
      sid_valid  = 1'($urandom_range(0, 1));
   endtask

   initial begin
      repeat (3) step(0, 0, 0, 0, 1);
      step(0, 0, 0, 1);

      step(0, 1, 0, 1);
      error_code = 32'h0007_0001;
      vita_time  = 64'h1_0000_0010;
      repeat (8) step(0, 0, 0, 1);

      step(1, 0, 0, 1);
      for (int unsigned i = 0; i < 12; i++) step(0, 0, 0, (i % 2) == 0);
      repeat (3) step(0, 0, 0, 1);

      repeat (3) step(1, 0, 0, 1);
      repeat (14) step(0, 0, 0, 1);

      step(0, 0, 1, 1);
      step(1, 0, 0, 1);
      step(0, 1, 0, 1);
      repeat (3) step(0, 0, 0, 1);
      step(1, 1, 0, 1);
      repeat (14) step(0, 0, 0, 1);

      step(1, 0, 0, 1);
      repeat (4) step(0, 0, 0, 1);
      step(0, 1, 0, 1);
      repeat (14) step(0, 0, 0, 1);

      for (int unsigned i = 0; i < 17; i++) begin
         step(1, 0, 0, 1);
         repeat (5) step(0, 0, 0, 1);
      end

      repeat (3) step(1, 0, 0, 1);
      step(0, 0, 1, 1);
      repeat (10) step(0, 0, 0, 1);

      step(0, 1, 0, 1);
      repeat (2) step(0, 0, 0, 1);
      step(0, 0, 0, 1, 1);
      repeat (3) step(0, 0, 0, 1);

      for (int unsigned i = 0; i < 4000; i++) begin
         step($urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0,
              $urandom_range(0, 49) == 0, $urandom_range(0, 9) < 7,
              $urandom_range(0, 299) == 0);
      end

      for (int unsigned i = 0; i < 60; i++) begin
         step(0, 0, 0, 1);
         if (rem == 0 && !pend) break;
      end
      step(0, 0, 0, 1);
      chk("drain_queue", 64'(expq.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
